sram_mem_ctrl: RTL

Memory-side controller directly downstream of the LC-3 datapath's MAR/MDR. It turns a single-cycle CPU access request into a timed async-SRAM cycle on the board SRAM. It drives the active-low CE/UB/LB/OE/WE strobes and the address, and owns the tri-state data bus. It returns read data to MDR and raises a one-cycle Ready pulse that the ISDU control FSM waits on, replacing fixed-count memory states.

---
 rtl/sram_mem_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_mem_ctrl.sv
// Purpose: sequences one CPU MAR/MDR access into a timed async-SRAM cycle and owns the shared data bus.
// Latency: Ready pulses WAIT_CYCLES+3 cycles after Req is sampled (1 cycle for a Byte_En==00 no-op).
// Backpressure: Req is only sampled in IDLE; Busy flags SETUP/ACCESS/HOLD and Req is ignored in DONE.
//
// Ports:
//   Clk, Reset      - rising-edge clock, asynchronous active-high reset
//   Req/Wr/Byte_En  - access request, direction and {upper,lower} lane enables (latched in IDLE)
//   Addr/Wdata      - access address and write data (latched in IDLE)
//   Rdata           - registered read data; disabled lanes read as zero
//   Ready/Busy      - one-cycle completion pulse / access in progress
//   SRAM_ADDR, SRAM_DQ, CE, UB, LB, OE, WE - SRAM pins; strobes active low, all registered
//   Access_Cnt      - present only when SRAM_ACCESS_CNT_EN is defined: count of completed real accesses
module sram_mem_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [1:0]        Byte_En,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Wdata,
    output logic [DATA_W-1:0] Rdata,
    output logic              Ready,
    output logic              Busy,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE
`ifdef SRAM_ACCESS_CNT_EN
    ,
    output logic [15:0]       Access_Cnt
`endif
);

    localparam int         HALF     = DATA_W / 2;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [1:0]          be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                real_q, real_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic                ce_q, ce_d;
    logic                ub_q, ub_d;
    logic                lb_q, lb_d;
    logic                oe_q, oe_d;
    logic                we_q, we_d;
    logic                dq_oe_q, dq_oe_d;
    logic                active;
    logic [DATA_W-1:0]   lane_mask;

    assign lane_mask = {{HALF{be_q[1]}}, {HALF{be_q[0]}}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        real_d  = real_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (Req) begin
                    if (Byte_En != 2'b00) begin
                        addr_d  = Addr;
                        wr_d    = Wr;
                        be_d    = Byte_En;
                        wdata_d = Wdata;
                        real_d  = 1'b1;
                        state_d = SETUP;
                    end else begin
                        // No lanes selected: complete immediately without touching the SRAM.
                        real_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    // Last OE-low cycle: SRAM data has settled, capture it on this edge.
                    if (!wr_q) begin
                        rdata_d = SRAM_DQ & lane_mask;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pin values are decoded from the next state so they appear registered
        // in the same cycle the FSM enters that state.
        active      = (state_d == SETUP) || (state_d == ACCESS) || (state_d == HOLD);
        ce_d        = !active;
        ub_d        = !(active && be_d[1]);
        lb_d        = !(active && be_d[0]);
        oe_d        = !((state_d == ACCESS) && !wr_d);
        we_d        = !((state_d == ACCESS) && wr_d);
        dq_oe_d     = active && wr_d;
        sram_addr_d = (state_d == SETUP) ? addr_d : sram_addr_q;
        ready_d     = (state_d == DONE);
        busy_d      = active;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            be_q        <= 2'b00;
            wdata_q     <= '0;
            real_q      <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            sram_addr_q <= '0;
            ce_q        <= 1'b1;
            ub_q        <= 1'b1;
            lb_q        <= 1'b1;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            real_q      <= real_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            sram_addr_q <= sram_addr_d;
            ce_q        <= ce_d;
            ub_q        <= ub_d;
            lb_q        <= lb_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

`ifdef SRAM_ACCESS_CNT_EN
    logic [15:0] acc_cnt_q, acc_cnt_d;

    // Counts DONE cycles of real accesses only; wraps naturally at 16 bits.
    always_comb begin
        acc_cnt_d = acc_cnt_q;
        if ((state_q == DONE) && real_q) begin
            acc_cnt_d = acc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_cnt_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign Access_Cnt = acc_cnt_q;
`endif

    assign SRAM_DQ   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign Rdata     = rdata_q;
    assign Ready     = ready_q;
    assign Busy      = busy_q;
    assign SRAM_ADDR = sram_addr_q;
    assign CE        = ce_q;
    assign UB        = ub_q;
    assign LB        = lb_q;
    assign OE        = oe_q;
    assign WE        = we_q;

endmodule
